// File: rtl/jk_seq_pkg.sv
// JK bank sequencer shared definitions: op encodings and FSM states.
// Imported by jk_drive_encode and jk_ff_bank_sequencer.
package jk_seq_pkg;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_SET    = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRIVE = 2'b01,
      CHECK = 2'b10,
      RESP  = 2'b11
   } state_t;

endpackage

// File: rtl/jk_drive_encode.sv
// Combinational op/mask/data/q -> J, K and expected post-edge Q.
// Ports: op, mask, data, q in; j, k, expected out (all WIDTH wide).
module jk_drive_encode
   import jk_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] mask,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] expected
);

   logic [WIDTH-1:0] j_raw;
   logic [WIDTH-1:0] k_raw;
   logic [WIDTH-1:0] nxt;

   always_comb begin
      j_raw = '0;
      k_raw = '0;
      nxt   = '0;
      case (op)
         OP_LOAD: begin
            // JK used as a D flop
            j_raw = data;
            k_raw = ~data;
            nxt   = data;
         end
         OP_SET: begin
            j_raw = '1;
            nxt   = '1;
         end
         OP_CLEAR: begin
            k_raw = '1;
            nxt   = '0;
         end
         default: begin
            j_raw = '1;
            k_raw = '1;
            nxt   = ~q;
         end
      endcase
   end

   assign j        = j_raw & mask;
   assign k        = k_raw & mask;
   assign expected = (q & ~mask) | (nxt & mask);

endmodule

// File: rtl/jk_ff_bank_sequencer.sv
// Sequences a bank of WIDTH JK flops: cmd handshake -> one J/K cycle -> Q readback.
// Ports: clk, rst (sync, active high); cmd_valid/ready/op/mask/data;
// jk_j, jk_k to bank; bank_q from bank; rsp_valid/ready/q/err.
// Optional: define JK_SEQ_RETRY_EN to re-drive once after a mismatch.
module jk_ff_bank_sequencer
   import jk_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_mask,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] jk_j,
   output logic [WIDTH-1:0] jk_k,
   input  logic [WIDTH-1:0] bank_q,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_q,
   output logic             rsp_err
);

   state_t           state;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] mask_r;
   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] expected_r;
`ifdef JK_SEQ_RETRY_EN
   logic             retried;
`endif

   logic [1:0]       enc_op;
   logic [WIDTH-1:0] enc_mask;
   logic [WIDTH-1:0] enc_data;
   logic [WIDTH-1:0] enc_j;
   logic [WIDTH-1:0] enc_k;
   logic [WIDTH-1:0] enc_exp;

   // In IDLE the encoder sees the incoming command so J/K can be
   // registered on the accept edge; afterwards it sees the held copy.
   assign enc_op   = (state == IDLE) ? cmd_op   : op_r;
   assign enc_mask = (state == IDLE) ? cmd_mask : mask_r;
   assign enc_data = (state == IDLE) ? cmd_data : data_r;

   jk_drive_encode #(.WIDTH(WIDTH)) u_enc (
      .op       (enc_op),
      .mask     (enc_mask),
      .data     (enc_data),
      .q        (bank_q),
      .j        (enc_j),
      .k        (enc_k),
      .expected (enc_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cmd_ready  <= 1'b1;
         jk_j       <= '0;
         jk_k       <= '0;
         rsp_valid  <= 1'b0;
         rsp_q      <= '0;
         rsp_err    <= 1'b0;
         op_r       <= OP_LOAD;
         mask_r     <= '0;
         data_r     <= '0;
         expected_r <= '0;
`ifdef JK_SEQ_RETRY_EN
         retried    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  op_r      <= cmd_op;
                  mask_r    <= cmd_mask;
                  data_r    <= cmd_data;
                  jk_j      <= enc_j;
                  jk_k      <= enc_k;
                  cmd_ready <= 1'b0;
                  state     <= DRIVE;
`ifdef JK_SEQ_RETRY_EN
                  retried   <= 1'b0;
`endif
               end
            end
            DRIVE: begin
               // bank_q is still pre-edge here; bank updates on this edge
               jk_j       <= '0;
               jk_k       <= '0;
               expected_r <= enc_exp;
               state      <= CHECK;
            end
            CHECK: begin
`ifdef JK_SEQ_RETRY_EN
               if ((bank_q != expected_r) && !retried) begin
                  retried <= 1'b1;
                  jk_j    <= enc_j;
                  jk_k    <= enc_k;
                  state   <= DRIVE;
               end else begin
                  rsp_q     <= bank_q;
                  rsp_err   <= (bank_q != expected_r);
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
`else
               rsp_q     <= bank_q;
               rsp_err   <= (bank_q != expected_r);
               rsp_valid <= 1'b1;
               state     <= RESP;
`endif
            end
            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
